// File: rtl/sorted_ram_loader_if.sv
// rtl/sorted_ram_loader_if.sv - load stream, read port and status bundle for sorted_ram_loader
interface sorted_ram_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              load_start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              loaded;
    logic              sort_err;
    logic [ADDR_W:0]   wr_count;

    modport master (
        output load_start, in_valid, in_data, rd_addr,
        input  in_ready, rd_data, loaded, sort_err, wr_count
    );

    modport slave (
        input  load_start, in_valid, in_data, rd_addr,
        output in_ready, rd_data, loaded, sort_err, wr_count
    );
endinterface

// File: rtl/sorted_ram_loader.sv
// rtl/sorted_ram_loader.sv - fills the search array from a byte stream and serves registered reads
// Optional order check and ERROR state enabled by defining SORT_CHECK_EN.
module sorted_ram_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input logic                clk,
    input logic                rst,
    sorted_ram_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, READY, ERROR} state_t;

    localparam logic [ADDR_W:0] C_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] C_ONE  = (ADDR_W+1)'(1);

    state_t            r_state;
    logic [ADDR_W:0]   r_wr_count;
    logic              r_loaded;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_wr_en;
    logic w_order_bad;

`ifdef SORT_CHECK_EN
    logic [DATA_W-1:0] r_prev;
    logic              r_sort_err;

    // The first word of a load has nothing to be compared against.
    assign w_order_bad  = (r_wr_count != '0) && (bus.in_data < r_prev);
    assign bus.sort_err = r_sort_err;
`else
    assign w_order_bad  = 1'b0;
    assign bus.sort_err = 1'b0;
`endif

    assign bus.in_ready = (r_state == LOAD);
    assign bus.loaded   = r_loaded;
    assign bus.wr_count = r_wr_count;
    assign bus.rd_data  = r_rd_data;

    // A restart pulse wins over a simultaneous word, so that word is never stored.
    assign w_wr_en = (r_state == LOAD) && bus.in_valid && !bus.load_start;

    always_ff @(posedge clk) begin
        if (rst && w_wr_en) begin
            r_mem[r_wr_count[ADDR_W-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[bus.rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wr_count <= '0;
            r_loaded   <= 1'b0;
`ifdef SORT_CHECK_EN
            r_sort_err <= 1'b0;
            r_prev     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, READY, ERROR: begin
                    if (bus.load_start) begin
                        r_state    <= LOAD;
                        r_wr_count <= '0;
                        r_loaded   <= 1'b0;
`ifdef SORT_CHECK_EN
                        r_sort_err <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (bus.load_start) begin
                        r_wr_count <= '0;
                    end else if (bus.in_valid) begin
                        r_wr_count <= r_wr_count + C_ONE;
`ifdef SORT_CHECK_EN
                        r_prev     <= bus.in_data;
`endif
                        if (w_order_bad) begin
                            r_state <= ERROR;
`ifdef SORT_CHECK_EN
                            r_sort_err <= 1'b1;
`endif
                        end else if (r_wr_count == C_LAST) begin
                            r_state  <= READY;
                            r_loaded <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sorted_ram_loader.sv
// tb/tb_sorted_ram_loader.sv - randomized self-checking bench for sorted_ram_loader
module tb_sorted_ram_loader;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sorted_ram_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sorted_ram_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit rand_rd = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the current load is just the list of accepted words.
    logic [7:0] m_mem [DEPTH];
    bit         m_known [DEPTH];
    logic [7:0] q [$];
    bit         m_active = 1'b0;
    logic [7:0] m_rd = 8'd0;
    bit         m_rd_known = 1'b0;

    function automatic bit m_err();
`ifdef SORT_CHECK_EN
        for (int i = 1; i < q.size(); i++) if (q[i] < q[i-1]) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        return m_active && !m_err() && (q.size() < DEPTH);
    endfunction

    function automatic bit m_loaded();
        return (q.size() == DEPTH) && !m_err();
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_active   = 1'b0;
            q.delete();
            m_rd       = 8'd0;
            m_rd_known = 1'b1;
        end else begin
            m_rd_known = m_known[bus.rd_addr];
            m_rd       = m_mem[bus.rd_addr];
            if (bus.load_start) begin
                m_active = 1'b1;
                q.delete();
            end else if (bus.in_valid && m_ready()) begin
                m_mem[q.size()]   = bus.in_data;
                m_known[q.size()] = 1'b1;
                q.push_back(bus.in_data);
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", int'(bus.in_ready), int'(m_ready()));
        chk("loaded",   int'(bus.loaded),   int'(m_loaded()));
        chk("sort_err", int'(bus.sort_err), int'(m_err()));
        chk("wr_count", int'(bus.wr_count), q.size());
        if (m_rd_known) chk("rd_data", int'(bus.rd_data), int'(m_rd));
    end

    always @(posedge clk) begin
        #2;
        if (rand_rd) bus.rd_addr = ADDR_W'($urandom_range(DEPTH - 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit gaps);
        bit acc;
        int g;
        acc = 1'b0;
        if (gaps) begin
            g = $urandom_range(2);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            repeat (g) tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic read_at(input int a, input int exp, input string name);
        rand_rd     = 1'b0;
        bus.rd_addr = ADDR_W'(a);
        tick();
        chk(name, int'(bus.rd_data), exp);
        rand_rd = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] v [DEPTH];
        int c0;
        int k;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'd0;
        bus.rd_addr    = '0;

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk("rst_loaded",   int'(bus.loaded), 0);
        chk("rst_sort_err", int'(bus.sort_err), 0);
        chk("rst_wr_count", int'(bus.wr_count), 0);
        chk("rst_rd_data",  int'(bus.rd_data), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        rst = 1'b1;

        // in_valid ignored while idle
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd7;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        chk("idle_wr_count", int'(bus.wr_count), 0);

        // Ramp 0,2,..,62 back to back
        start_load();
        c0 = cyc;
        for (int i = 0; i < DEPTH; i++) send(8'(2 * i), 1'b0);
        chk("ramp_cycles",   cyc - c0, 32);
        chk("ramp_loaded",   int'(bus.loaded), 1);
        chk("ramp_wr_count", int'(bus.wr_count), 32);
        read_at(15, 30, "ramp_rd15");

        // All equal words
        start_load();
        for (int i = 0; i < DEPTH; i++) send(8'd5, 1'b1);
        chk("eq_loaded",   int'(bus.loaded), 1);
        chk("eq_sort_err", int'(bus.sort_err), 0);

        // 10,20,15
        start_load();
        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        send(8'd15, 1'b0);
`ifdef SORT_CHECK_EN
        chk("err_sort_err", int'(bus.sort_err), 1);
        chk("err_in_ready", int'(bus.in_ready), 0);
        chk("err_wr_count", int'(bus.wr_count), 3);
        read_at(2, 15, "err_mem2");
`else
        for (int i = 1; i < DEPTH - 2; i++) send(8'(15 + i), 1'b0);
        chk("nochk_loaded",   int'(bus.loaded), 1);
        chk("nochk_sort_err", int'(bus.sort_err), 0);
`endif

        // Restart during a transfer drops the word
        start_load();
        for (int i = 0; i < 10; i++) send(8'(3 * i), 1'b0);
        bus.load_start = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'd99;
        tick();
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        chk("drop_wr_count", int'(bus.wr_count), 0);
        chk("drop_in_ready", int'(bus.in_ready), 1);
        rand_rd     = 1'b0;
        bus.rd_addr = ADDR_W'(10);
        tick();
        chk("drop_not99", int'(bus.rd_data != 8'd99), 1);
        rand_rd = 1'b1;
        for (int i = 0; i < DEPTH; i++) send(8'(4 * i + 1), 1'b1);
        chk("drop_full_loaded", int'(bus.loaded), 1);

        // Reset in the middle of a reload from READY
        start_load();
        for (int i = 0; i < 4; i++) send(8'(100 + i), 1'b0);
        rst = 1'b0;
        tick();
        chk("midrst_loaded",   int'(bus.loaded), 0);
        chk("midrst_wr_count", int'(bus.wr_count), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) read_at(i, 100 + i, "midrst_mem");

        // Randomized loads, some with one order violation
        repeat (8) begin
            start_load();
            v[0] = 8'($urandom_range(31));
            for (int i = 1; i < DEPTH; i++) v[i] = v[i-1] + 8'($urandom_range(7));
            if ($urandom_range(2) == 0) begin
                k = $urandom_range(DEPTH - 1, 1);
                if (v[k-1] != 8'd0) v[k] = v[k-1] - 8'd1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (m_err()) break;
                send(v[i], 1'b1);
            end
            repeat (2) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
